// File: rtl/odu_pkg.sv
// Purpose: shared constants for the ODU generator/checker pair (channel count, word layout).
// Latency: n/a (constants only).
// Backpressure: n/a.
package odu_pkg;
    localparam int NUM_CH         = 80;
    localparam int DATA_W         = 395;
    localparam int SEQ_W          = 32;
    localparam int CHID_W         = 7;
    localparam int PAD_W          = 4;
    // Word layout, MSB to LSB: chid echo | seq | pad | {PAYLOAD_COPIES{seq}}
    localparam int ECHO_LSB       = 388;
    localparam int SEQ_LSB        = 356;
    localparam int PAD_LSB        = 352;
    localparam int PAYLOAD_COPIES = 11;
endpackage

// File: rtl/odu_word_check.sv
// Purpose: field extraction and self-consistency check of one ODU word (echo, pad, payload copies).
// Latency: combinational.
// Backpressure: none.
// Ports: data/chid in; seq = extracted sequence field; fmt_err = echo, pad or payload mismatch.
module odu_word_check
    import odu_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [CHID_W-1:0] chid,
    output logic [SEQ_W-1:0]  seq,
    output logic              fmt_err
);

    logic [CHID_W-1:0] echo;
    logic [PAD_W-1:0]  pad;
    logic              payload_err;

    assign echo = data[ECHO_LSB +: CHID_W];
    assign seq  = data[SEQ_LSB +: SEQ_W];
    assign pad  = data[PAD_LSB +: PAD_W];

    // Every payload copy must repeat the header sequence number.
    always_comb begin
        payload_err = 1'b0;
        for (int i = 0; i < PAYLOAD_COPIES; i++) begin
            if (data[i*SEQ_W +: SEQ_W] != seq) begin
                payload_err = 1'b1;
            end
        end
    end

    assign fmt_err = (echo != chid) | (pad != '0) | payload_err;

endmodule

// File: rtl/odu_data_check.sv
// Purpose: per-channel ODU receive checker (echo/pad/payload/sequence) with sticky errors and counters.
// Latency: word sampled at edge N, state/outputs updated at edge N+1; clear takes effect at the next edge.
// Backpressure: none; one word per cycle accepted unconditionally when i_valid is high.
// Ports: i_valid/i_chid/i_data word input; i_clear_chid per-channel clear pulse;
//        o_error_chid/o_locked_chid per-channel status; o_bad_chid sticky out-of-range chid;
//        o_err_count saturating errored-word count; o_word_count wrapping valid-word count.
module odu_data_check
    import odu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [CHID_W-1:0] i_chid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0] i_clear_chid,
    output logic [NUM_CH-1:0] o_error_chid,
    output logic [NUM_CH-1:0] o_locked_chid,
    output logic              o_bad_chid,
    output logic [15:0]       o_err_count,
    output logic [31:0]       o_word_count
);

    // Stage 1: plain input register.
    logic              s1_valid;
    logic [CHID_W-1:0] s1_chid;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_chid  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= i_valid;
            s1_chid  <= i_chid;
            s1_data  <= i_data;
        end
    end

    // Stage 2: check and state update.
    logic [SEQ_W-1:0]  rx_seq;
    logic              fmt_err;
    logic [SEQ_W-1:0]  exp_seq [NUM_CH];
    logic [NUM_CH-1:0] error_q;
    logic [NUM_CH-1:0] locked_q;
    logic [SEQ_W-1:0]  rd_exp;
    logic              rd_locked;
    logic              chid_bad;
    logic              seq_err;
    logic              word_err;
    logic              hit;
    logic              count_err;
    logic              bad_q;
    logic [15:0]       err_cnt;
    logic [31:0]       word_cnt;

    odu_word_check u_word_check (
        .data    (s1_data),
        .chid    (s1_chid),
        .seq     (rx_seq),
        .fmt_err (fmt_err)
    );

    assign chid_bad = (s1_chid >= CHID_W'(NUM_CH));

    // Explicit mux keeps out-of-range chids from indexing past the table.
    always_comb begin
        rd_exp    = '0;
        rd_locked = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (s1_chid == CHID_W'(n)) begin
                rd_exp    = exp_seq[n];
                rd_locked = locked_q[n];
            end
        end
    end

    // Unlocked channels skip the sequence check; the first word only seeds exp_seq.
    assign seq_err   = rd_locked && (rx_seq != rd_exp);
    assign word_err  = fmt_err | seq_err;
    assign hit       = s1_valid && !chid_bad;
    assign count_err = s1_valid && (chid_bad || word_err);

    // A word for channel n takes priority over a simultaneous clear of n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q  <= '0;
            locked_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                exp_seq[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (hit && (s1_chid == CHID_W'(n))) begin
                    locked_q[n] <= 1'b1;
                    exp_seq[n]  <= rx_seq + SEQ_W'(1);
                    error_q[n]  <= word_err | (error_q[n] & ~i_clear_chid[n]);
                end else if (i_clear_chid[n]) begin
                    locked_q[n] <= 1'b0;
                    error_q[n]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_q    <= 1'b0;
            err_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (s1_valid) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (s1_valid && chid_bad) begin
                bad_q <= 1'b1;
            end
            if (count_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign o_error_chid  = error_q;
    assign o_locked_chid = locked_q;
    assign o_bad_chid    = bad_q;
    assign o_err_count   = err_cnt;
    assign o_word_count  = word_cnt;

endmodule
